// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encodings and latency defaults for the pipeline stall controller
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_t;

   typedef enum logic {
      MEM_IDLE = 1'b0,
      MEM_WAIT = 1'b1
   } mem_state_t;

   localparam int DEF_MUL_LAT = 3;
   localparam int DEF_DIV_LAT = 33;
   localparam int CNT_W       = 6;

   // The go cycle and the final BUSY cycle both count toward the latency.
   function automatic logic [CNT_W-1:0] lat_preload(input int lat);
      return CNT_W'(lat - 2);
   endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - hazard inputs and stall/request outputs of the pipeline stall controller
interface pipe_stall_ctrl_if;

   logic [4:0] ID_rs;
   logic [4:0] ID_rt;
   logic       ID_uses_rs;
   logic       ID_uses_rt;
   logic       EX_is_load;
   logic [4:0] EX_wdest;
   logic       EX_md_start;
   logic       EX_md_is_div;
   logic       MEM_req;
   logic       data_sram_ack;

   logic       IF_stall;
   logic       ID_stall;
   logic       EX_stall;
   logic       MEM_stall;
   logic       md_go;
   logic       data_sram_en;

   modport master (
      output ID_rs, ID_rt, ID_uses_rs, ID_uses_rt,
      output EX_is_load, EX_wdest, EX_md_start, EX_md_is_div,
      output MEM_req, data_sram_ack,
      input  IF_stall, ID_stall, EX_stall, MEM_stall, md_go, data_sram_en
   );

   modport slave (
      input  ID_rs, ID_rt, ID_uses_rs, ID_uses_rt,
      input  EX_is_load, EX_wdest, EX_md_start, EX_md_is_div,
      input  MEM_req, data_sram_ack,
      output IF_stall, ID_stall, EX_stall, MEM_stall, md_go, data_sram_en
   );

endinterface

// File: rtl/md_seq.sv
// rtl/md_seq.sv - multiply/divide sequencer that holds EX for the unit's fixed latency
module md_seq
   import pipe_ctrl_pkg::*;
#(
   parameter int MUL_LAT = DEF_MUL_LAT,
   parameter int DIV_LAT = DEF_DIV_LAT
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic is_div,
   input  logic hold,
   output logic go,
   output logic stall
);

   localparam logic [CNT_W-1:0] MUL_PRE = lat_preload(MUL_LAT);
   localparam logic [CNT_W-1:0] DIV_PRE = lat_preload(DIV_LAT);

   md_state_t        state;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= MD_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (start && !hold) begin
                  state <= MD_BUSY;
                  cnt   <= is_div ? DIV_PRE : MUL_PRE;
               end
            end
            MD_BUSY: begin
               // The unit keeps computing while MEM holds the pipeline.
               if (cnt == '0) begin
                  state <= MD_DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            MD_DONE: begin
               if (!hold) begin
                  state <= MD_IDLE;
               end
            end
            default: begin
               state <= MD_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign go    = !rst && (state == MD_IDLE) && start && !hold;
   assign stall = !rst && (((state == MD_IDLE) && start) || (state == MD_BUSY));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - per-stage stall generation for load-use, mult/div and data SRAM waits
module pipe_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MUL_LAT = DEF_MUL_LAT,
   parameter int DIV_LAT = DEF_DIV_LAT
) (
   input  logic               clk,
   input  logic               rst,
   pipe_stall_ctrl_if.slave   bus
);

   mem_state_t mem_state;
   logic       mem_stall;
   logic       md_stall;
   logic       md_go;
   logic       lu;
   logic       rs_hit;
   logic       rt_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_state <= MEM_IDLE;
      end else begin
         case (mem_state)
            MEM_IDLE: if (bus.MEM_req)       mem_state <= MEM_WAIT;
            MEM_WAIT: if (bus.data_sram_ack) mem_state <= MEM_IDLE;
            default:                         mem_state <= MEM_IDLE;
         endcase
      end
   end

   // A stray ack while idle belongs to nobody and is dropped.
   assign mem_stall = !rst && (((mem_state == MEM_IDLE) && bus.MEM_req) ||
                               ((mem_state == MEM_WAIT) && !bus.data_sram_ack));

   md_seq #(
      .MUL_LAT (MUL_LAT),
      .DIV_LAT (DIV_LAT)
   ) u_md_seq (
      .clk    (clk),
      .rst    (rst),
      .start  (bus.EX_md_start),
      .is_div (bus.EX_md_is_div),
      .hold   (mem_stall),
      .go     (md_go),
      .stall  (md_stall)
   );

   // r0 is hardwired zero, so a load targeting it never creates a dependency.
   assign rs_hit = bus.ID_uses_rs && (bus.ID_rs == bus.EX_wdest);
   assign rt_hit = bus.ID_uses_rt && (bus.ID_rt == bus.EX_wdest);
   assign lu     = !rst && bus.EX_is_load && (bus.EX_wdest != 5'd0) && (rs_hit || rt_hit);

   assign bus.MEM_stall    = mem_stall;
   assign bus.EX_stall     = mem_stall || md_stall;
   assign bus.ID_stall     = mem_stall || md_stall || lu;
   assign bus.IF_stall     = mem_stall || md_stall || lu;
   assign bus.md_go        = md_go;
   assign bus.data_sram_en = !rst && (mem_state == MEM_IDLE) && bus.MEM_req;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed-vector bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   pipe_stall_ctrl_if bus ();

   pipe_stall_ctrl #(
      .MUL_LAT (3),
      .DIV_LAT (33)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // {IF_stall, ID_stall, EX_stall, MEM_stall, md_go, data_sram_en}
   function automatic logic [5:0] outs();
      return {bus.IF_stall, bus.ID_stall, bus.EX_stall, bus.MEM_stall, bus.md_go, bus.data_sram_en};
   endfunction

   task automatic clear_in();
      bus.ID_rs         = 5'd0;
      bus.ID_rt         = 5'd0;
      bus.ID_uses_rs    = 1'b0;
      bus.ID_uses_rt    = 1'b0;
      bus.EX_is_load    = 1'b0;
      bus.EX_wdest      = 5'd0;
      bus.EX_md_start   = 1'b0;
      bus.EX_md_is_div  = 1'b0;
      bus.MEM_req       = 1'b0;
      bus.data_sram_ack = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   initial begin
      logic s;
      checks = 0;
      errors = 0;

      // Reset cycle with every hazard source active
      clear_in();
      rst = 1'b1;
      bus.ID_rs = 5'd5; bus.ID_uses_rs = 1'b1; bus.EX_is_load = 1'b1; bus.EX_wdest = 5'd5;
      bus.EX_md_start = 1'b1; bus.MEM_req = 1'b1;
      settle();
      check("rst_outs", 32'(outs()), 32'h00);
      next_cycle();
      rst = 1'b0;
      clear_in();
      settle();
      check("idle_outs", 32'(outs()), 32'h00);

      // Load-use hazard
      bus.ID_rs = 5'd5; bus.ID_uses_rs = 1'b1; bus.EX_is_load = 1'b1; bus.EX_wdest = 5'd5;
      settle();
      check("lu_rs", 32'(outs()), 32'b110000);
      bus.EX_wdest = 5'd0; bus.ID_rs = 5'd0;
      settle();
      check("lu_r0", 32'(outs()), 32'h00);
      clear_in();
      bus.ID_rt = 5'd7; bus.ID_uses_rt = 1'b1; bus.EX_is_load = 1'b1; bus.EX_wdest = 5'd7;
      settle();
      check("lu_rt", 32'(outs()), 32'b110000);
      bus.ID_uses_rt = 1'b0;
      settle();
      check("lu_rt_unused", 32'(outs()), 32'h00);
      bus.ID_uses_rt = 1'b1; bus.EX_is_load = 1'b0;
      settle();
      check("lu_not_load", 32'(outs()), 32'h00);

      // Multiply: EX held cycles 0-2
      next_cycle();
      clear_in();
      bus.EX_md_start = 1'b1;
      for (int c = 0; c <= 3; c++) begin
         settle();
         s = (c <= 2);
         check($sformatf("mul_c%0d", c), 32'(outs()), 32'({s, s, s, 1'b0, (c == 0), 1'b0}));
         next_cycle();
         bus.EX_md_start = 1'b0;
      end

      // Divide: EX held cycles 0-32
      bus.EX_md_start = 1'b1; bus.EX_md_is_div = 1'b1;
      for (int c = 0; c <= 33; c++) begin
         settle();
         s = (c <= 32);
         check($sformatf("div_c%0d", c), 32'(outs()), 32'({s, s, s, 1'b0, (c == 0), 1'b0}));
         next_cycle();
         bus.EX_md_start = 1'b0;
      end
      clear_in();

      // SRAM access with ack at cycle 4
      bus.MEM_req = 1'b1;
      for (int c = 0; c <= 4; c++) begin
         bus.data_sram_ack = (c == 4);
         settle();
         s = (c <= 3);
         check($sformatf("mem_c%0d", c), 32'(outs()), 32'({s, s, s, s, 1'b0, (c == 0)}));
         next_cycle();
      end
      clear_in();

      // Ack while idle is ignored; the next request still stalls
      bus.data_sram_ack = 1'b1;
      settle();
      check("ack_idle", 32'(outs()), 32'h00);
      next_cycle();
      bus.data_sram_ack = 1'b0; bus.MEM_req = 1'b1;
      settle();
      check("req_after_stray_ack", 32'(outs()), 32'b111101);
      next_cycle();
      bus.MEM_req = 1'b0; bus.data_sram_ack = 1'b1;
      settle();
      check("ack_release", 32'(outs()), 32'h00);
      next_cycle();
      clear_in();

      // Multiply finishes while MEM is stalled cycles 1-6
      bus.EX_md_start = 1'b1;
      settle();
      check("mdmem_c0", 32'(outs()), 32'b111010);
      next_cycle();
      bus.EX_md_start = 1'b0; bus.MEM_req = 1'b1;
      settle();
      check("mdmem_c1", 32'(outs()), 32'b111101);
      for (int c = 2; c <= 6; c++) begin
         next_cycle();
         settle();
         check($sformatf("mdmem_c%0d", c), 32'(outs()), 32'b111100);
      end
      next_cycle();
      bus.data_sram_ack = 1'b1;
      settle();
      check("mdmem_c7", 32'(outs()), 32'h00);
      next_cycle();
      clear_in();
      bus.EX_md_start = 1'b1;
      settle();
      check("mdmem_restart", 32'(outs()), 32'b111010);
      for (int c = 1; c <= 3; c++) begin
         next_cycle();
         bus.EX_md_start = 1'b0;
         settle();
         s = (c <= 2);
         check($sformatf("mdmem_rerun_c%0d", c), 32'(outs()), 32'({s, s, s, 3'b000}));
      end
      next_cycle();

      // Simultaneous SRAM request and mult start: go waits for MEM
      bus.EX_md_start = 1'b1; bus.MEM_req = 1'b1;
      settle();
      check("both_c0", 32'(outs()), 32'b111101);
      next_cycle();
      bus.MEM_req = 1'b0; bus.data_sram_ack = 1'b1;
      settle();
      check("both_c1", 32'(outs()), 32'b111010);
      next_cycle();
      clear_in();
      settle();
      check("both_c2", 32'(outs()), 32'b111000);
      next_cycle();
      settle();
      check("both_c3", 32'(outs()), 32'b111000);
      next_cycle();
      settle();
      check("both_c4", 32'(outs()), 32'h00);
      next_cycle();

      // Reset abandons a divide at cycle 10
      bus.EX_md_start = 1'b1; bus.EX_md_is_div = 1'b1;
      settle();
      check("rstdiv_c0", 32'(outs()), 32'b111010);
      for (int c = 1; c <= 9; c++) begin
         next_cycle();
         bus.EX_md_start = 1'b0;
      end
      settle();
      check("rstdiv_c9", 32'(outs()), 32'b111000);
      next_cycle();
      rst = 1'b1;
      bus.EX_md_start = 1'b1; bus.MEM_req = 1'b1;
      bus.ID_rs = 5'd3; bus.ID_uses_rs = 1'b1; bus.EX_is_load = 1'b1; bus.EX_wdest = 5'd3;
      settle();
      check("rstdiv_c10", 32'(outs()), 32'h00);
      next_cycle();
      rst = 1'b0;
      clear_in();
      bus.EX_md_start = 1'b1;
      settle();
      check("rstdiv_c11", 32'(outs()), 32'b111010);
      for (int c = 12; c <= 14; c++) begin
         next_cycle();
         bus.EX_md_start = 1'b0;
         settle();
         s = (c <= 13);
         check($sformatf("rstdiv_c%0d", c), 32'(outs()), 32'({s, s, s, 3'b000}));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3, total EX stall cycles for a multiply (range 2..63).
REQ-002 SHALL have parameter DIV_LAT, default 33, total EX stall cycles for a divide (range 2..63).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports ID_rs, ID_rt  in  5 each  source register numbers of the instruction in ID.
REQ-006 SHALL have ports ID_uses_rs, ID_uses_rt  in  1 each  ID instruction reads rs / rt.
REQ-007 SHALL have port EX_is_load  in  1  instruction in EX is a load.
REQ-008 SHALL have port EX_wdest  in  5  EX destination register number.
REQ-009 SHALL have port EX_md_start  in  1  EX holds a mult/div that has not started.
REQ-010 SHALL have port EX_md_is_div  in  1  1 = divide, 0 = multiply; valid with EX_md_start.
REQ-011 SHALL have port MEM_req  in  1  MEM holds a data SRAM load/store.
REQ-012 SHALL have port data_sram_ack  in  1  data SRAM completion, one-cycle pulse.
REQ-013 SHALL have ports IF_stall, ID_stall, EX_stall, MEM_stall  out  1 each  per-stage hold; a held stage's downstream pipeline register loads a bubble unless that stage is also held.
REQ-014 SHALL have port md_go  out  1  one-cycle start pulse to the mult/div unit.
REQ-015 SHALL have port data_sram_en  out  1  one-cycle request pulse to the data SRAM.

Function
REQ-016 Load-use hazard lu = EX_is_load & EX_wdest!=0 & ((ID_uses_rs & ID_rs==EX_wdest) | (ID_uses_rt & ID_rt==EX_wdest)), combinational.
REQ-017 MD FSM states IDLE, BUSY, DONE; IDLE->BUSY when EX_md_start & !MEM_stall, md_go=1 that cycle, counter loaded with LAT-2 (LAT per EX_md_is_div).
REQ-018 In BUSY, counter decrements every cycle regardless of MEM_stall; at counter==0 go to DONE.
REQ-019 DONE -> IDLE only when MEM_stall=0; the instruction leaves EX that cycle, so a done result is never dropped.
REQ-020 md_stall = (IDLE & EX_md_start) | BUSY; EX_stall is deasserted in DONE, so EX_stall is high for exactly LAT cycles when MEM is not stalled.
REQ-021 MEM FSM states IDLE, WAIT; IDLE->WAIT when MEM_req, data_sram_en=1 that cycle only; WAIT->IDLE on data_sram_ack.
REQ-022 mem_stall = (IDLE & MEM_req) | (WAIT & !data_sram_ack); an ack in IDLE is ignored.
REQ-023 MEM_stall = mem_stall; EX_stall = MEM_stall | md_stall; ID_stall = EX_stall | lu; IF_stall = ID_stall.
REQ-024 All four stall outputs and md_go/data_sram_en are combinational from FSM state and inputs; no extra latency.
REQ-025 Simultaneous MEM_req and EX_md_start: both FSMs advance independently; EX_stall covers both.

Reset
REQ-026 On rst, both FSMs go to IDLE and the counter to 0; an in-flight mult/div or SRAM wait is abandoned.
REQ-027 During the rst cycle, all outputs SHALL be 0 regardless of other inputs.

Structure
REQ-028 Package pipe_ctrl_pkg SHALL hold MD/MEM state encodings and default MUL_LAT/DIV_LAT constants.
REQ-029 MD FSM and counter SHALL be sub-module md_seq (ports clk, rst, start, is_div, hold, go, stall); MEM FSM and hazard logic stay at top level.

Verification
REQ-030 ID_rs=5, ID_uses_rs=1, EX_is_load=1, EX_wdest=5 -> ID_stall=IF_stall=1, EX_stall=0; same with EX_wdest=0 -> all 0.
REQ-031 EX_md_start=1, EX_md_is_div=0 at cycle 0 -> md_go at cycle 0 only, EX_stall high cycles 0-2, low cycle 3.
REQ-032 Divide start at cycle 0 -> EX_stall high cycles 0-32, low cycle 33; ID_stall and IF_stall track it.
REQ-033 MEM_req=1 at cycle 0, ack at cycle 4 -> data_sram_en at cycle 0 only, MEM_stall/EX_stall/ID_stall high cycles 0-3, low cycle 4.
REQ-034 Multiply started, MEM stalled cycles 1-6 -> md stays DONE until cycle 7, EX_stall high through 6, no second md_go.
REQ-035 rst asserted mid-divide at cycle 10 -> cycle 10 all outputs 0; cycle 11 with EX_md_start=1 issues fresh md_go.
